// File: rtl/rs_dsp_pkg.sv
// Shared types and constants for the DSP38 multiplier arbiter.
// FIFO entries carry the product and the issuing requester id.
package rs_dsp_pkg;

  localparam int DSP_A_W = 20;
  localparam int DSP_B_W = 18;
  localparam int DSP_Z_W = 38;
  localparam int ID_MAX_W = 4;

  localparam logic [2:0] FB_MULT = 3'b000;

  typedef struct packed {
    logic [DSP_Z_W-1:0]  z;
    logic [ID_MAX_W-1:0] id;
  } rs_dsp_entry_t;

endpackage

// File: rtl/DSP38.sv
// Behavioural DSP38 in multiply mode: no input register,
// registered 38-bit product, active-high async RESET.
module DSP38
  import rs_dsp_pkg::*;
(
  input  logic [DSP_A_W-1:0] A,
  input  logic [DSP_B_W-1:0] B,
  input  logic [2:0]         FEEDBACK,
  input  logic               UNSIGNED_A,
  input  logic               UNSIGNED_B,
  input  logic               CLK,
  input  logic               RESET,
  output logic [DSP_Z_W-1:0] Z
);

  logic [DSP_Z_W-1:0] a_x;
  logic [DSP_Z_W-1:0] b_x;
  logic [DSP_Z_W-1:0] p;

  assign a_x = {{(DSP_Z_W-DSP_A_W){~UNSIGNED_A & A[DSP_A_W-1]}}, A};
  assign b_x = {{(DSP_Z_W-DSP_B_W){~UNSIGNED_B & B[DSP_B_W-1]}}, B};
  assign p   = a_x * b_x;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Z <= '0;
    end else if (FEEDBACK == FB_MULT) begin
      Z <= p;
    end
  end

endmodule

// File: rtl/rs_dsp_rr_arbiter.sv
// Round-robin pick: first request at or above ptr, modulo NUM_REQ.
// Grant is suppressed when en is low; the index is always produced.
module rs_dsp_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic found;
  int   j;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
    if (found && en) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rs_dsp_mult_arbiter.sv
// Shares one DSP38 multiplier among NUM_REQ requesters with
// round-robin issue, id-tagged in-order results and a credit FIFO.
module rs_dsp_mult_arbiter
  import rs_dsp_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int FIFO_DEPTH = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      lreset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DSP_A_W-1:0] req_a,
  input  logic [NUM_REQ*DSP_B_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_unsigned_a,
  input  logic [NUM_REQ-1:0]        req_unsigned_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DSP_Z_W-1:0]        res_z,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    inflight_id;
  logic [NUM_REQ-1:0] gnt;
  logic               inflight_v;
  logic               issue;
  logic               pop;
  logic               push;
  logic               credit;
  logic               en;
  logic [CW:0]        occ;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  rs_dsp_entry_t      mem [FIFO_DEPTH];
  rs_dsp_entry_t      head;

  logic [DSP_A_W-1:0] dsp_a;
  logic [DSP_B_W-1:0] dsp_b;
  logic               dsp_ua;
  logic               dsp_ub;
  logic [DSP_Z_W-1:0] dsp_z;

  // Slots already committed after this cycle's pop; res_ready feeds req_ready.
  assign pop    = res_valid & res_ready;
  assign push   = inflight_v;
  assign occ    = {1'b0, count} + (CW+1)'(inflight_v) - (CW+1)'(pop);
  assign credit = occ < (CW+1)'(FIFO_DEPTH);
  assign en     = credit & lreset;

  rs_dsp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .en      (en),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign issue     = |(req_valid & gnt);

  assign dsp_a  = req_a[DSP_A_W*gnt_idx +: DSP_A_W];
  assign dsp_b  = req_b[DSP_B_W*gnt_idx +: DSP_B_W];
  assign dsp_ua = req_unsigned_a[gnt_idx];
  assign dsp_ub = req_unsigned_b[gnt_idx];

  DSP38 u_dsp (
    .A          (dsp_a),
    .B          (dsp_b),
    .FEEDBACK   (FB_MULT),
    .UNSIGNED_A (dsp_ua),
    .UNSIGNED_B (dsp_ub),
    .CLK        (clk),
    .RESET      (~lreset),
    .Z          (dsp_z)
  );

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      ptr         <= '0;
      inflight_v  <= 1'b0;
      inflight_id <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      inflight_v <= issue;
      if (issue) begin
        inflight_id <= gnt_idx;
        ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{z: dsp_z, id: ID_MAX_W'(inflight_id)};
  end

  assign head      = mem[rd_ptr];
  assign res_valid = count != '0;
  assign res_z     = head.z;
  assign res_id    = ID_W'(head.id);
  assign busy      = inflight_v | (count != '0);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!lreset)
    !(push && !pop && count == CW'(FIFO_DEPTH))
  );

endmodule
